// File: rtl/draw_sequencer_if.sv
// Channel and VGA write-port bundle for draw_sequencer.
//
// The master side (the sequencer) receives per-channel coordinates, colour,
// write requests and done levels from the drawers. It returns a one-hot
// enable to the drawers and drives the single VGA write port.
// Channel k occupies bits [k*W +: W] of each packed per-channel vector.
// The slave modport is the drawer/VGA view of the same signals.
interface draw_sequencer_if #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned X_W    = 9,
   parameter int unsigned Y_W    = 8,
   parameter int unsigned C_W    = 6
);
   logic [NUM_CH*X_W-1:0] ch_x;
   logic [NUM_CH*Y_W-1:0] ch_y;
   logic [NUM_CH*C_W-1:0] ch_colour;
   logic [NUM_CH-1:0]     ch_write;
   logic [NUM_CH-1:0]     ch_done;
   logic [NUM_CH-1:0]     ch_enable;
   logic [X_W-1:0]        x_position;
   logic [Y_W-1:0]        y_position;
   logic [C_W-1:0]        colour;
   logic                  VGA_enable;

   modport master (
      input  ch_x, ch_y, ch_colour, ch_write, ch_done,
      output ch_enable, x_position, y_position, colour, VGA_enable
   );

   modport slave (
      output ch_x, ch_y, ch_colour, ch_write, ch_done,
      input  ch_enable, x_position, y_position, colour, VGA_enable
   );
endinterface

// File: rtl/draw_sequencer.sv
// Frame pacer and VGA draw arbiter.
//
// A free-running counter produces frame_tick once every FRAME_COUNT clocks.
// On a tick with go high, the sequencer grants the VGA write port to each
// channel selected in the latched mask, in ascending order. Channel 0 draws
// first and the highest channel draws last, so it ends up on top.
//
// Ports:
//   clock, reset : system clock, asynchronous active-low reset.
//   go           : run enable. Frames start only while it is high.
//   ch_mask      : channels to draw. Latched at frame start.
//   overrun_clr  : clears the sticky overrun flag.
//   bus          : channel inputs, one-hot ch_enable and the VGA write port.
//   frame_tick   : one-cycle pulse at each frame boundary.
//   frame_done   : one-cycle pulse after all masked channels are finished.
//   busy         : high whenever the sequencer is not idle.
//   overrun      : sticky. Set when a tick arrives while the sequencer is busy.
//   frame_count  : number of completed frames. Wraps at 16 bits.
module draw_sequencer #(
   parameter int unsigned NUM_CH      = 3,
   parameter int unsigned X_W         = 9,
   parameter int unsigned Y_W         = 8,
   parameter int unsigned C_W         = 6,
   parameter int unsigned FRAME_COUNT = 833333,
   parameter int unsigned CNT_W       = 24
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              go,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              overrun_clr,
   draw_sequencer_if.master  bus,
   output logic              frame_tick,
   output logic              frame_done,
   output logic              busy,
   output logic              overrun,
   output logic [15:0]       frame_count
);

   // cur must be able to point one past the last channel, so SCAN can find nothing.
   localparam int unsigned CUR_W = $clog2(NUM_CH + 1);

   typedef enum logic [1:0] {StIdle, StScan, StDraw, StFin} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               tick_q, tick_d;
   logic [NUM_CH-1:0]  mask_q, mask_d;
   logic [NUM_CH-1:0]  ch_enable_q, ch_enable_d;
   logic [CUR_W-1:0]   cur_q, cur_d;
   logic               overrun_q, overrun_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;

   logic               cnt_last;
   logic [X_W-1:0]     sel_x;
   logic [Y_W-1:0]     sel_y;
   logic [C_W-1:0]     sel_colour;
   logic               sel_write;
   logic               sel_done;
   logic               scan_found;
   logic [CUR_W-1:0]   scan_idx;
   logic               draw_pass;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         tick_q      <= 1'b0;
         mask_q      <= '0;
         ch_enable_q <= '0;
         cur_q       <= '0;
         overrun_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         mask_q      <= mask_d;
         ch_enable_q <= ch_enable_d;
         cur_q       <= cur_d;
         overrun_q   <= overrun_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Pick out the fields of channel cur. Out-of-range cur selects zeros.
   always_comb begin
      sel_x      = '0;
      sel_y      = '0;
      sel_colour = '0;
      sel_write  = 1'b0;
      sel_done   = 1'b0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         if (cur_q == CUR_W'(k)) begin
            sel_x      = bus.ch_x[k*X_W +: X_W];
            sel_y      = bus.ch_y[k*Y_W +: Y_W];
            sel_colour = bus.ch_colour[k*C_W +: C_W];
            sel_write  = bus.ch_write[k];
            sel_done   = bus.ch_done[k];
         end
      end
   end

   // Lowest masked channel at or above cur. The downward loop leaves the lowest match.
   always_comb begin
      scan_found = 1'b0;
      scan_idx   = '0;
      for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
         if (mask_q[k] && (CUR_W'(k) >= cur_q)) begin
            scan_found = 1'b1;
            scan_idx   = CUR_W'(k);
         end
      end
   end

   // Next-state logic
   always_comb begin
      cnt_last    = (cnt_q == CNT_W'(FRAME_COUNT - 1));
      cnt_d       = cnt_last ? '0 : cnt_q + 1'b1;
      tick_d      = cnt_last;
      state_d     = state_q;
      mask_d      = mask_q;
      cur_d       = cur_q;
      ch_enable_d = ch_enable_q;
      frame_cnt_d = frame_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (tick_q && go) begin
               mask_d  = ch_mask;
               cur_d   = '0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (scan_found) begin
               cur_d       = scan_idx;
               ch_enable_d = NUM_CH'(1) << scan_idx;
               state_d     = StDraw;
            end else begin
               state_d = StFin;
            end
         end
         StDraw: begin
            if (sel_done) begin
               ch_enable_d = '0;
               cur_d       = cur_q + 1'b1;
               state_d     = StScan;
            end
         end
         StFin: begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Set has priority over clear. A tick that arrives while busy is dropped.
      if (tick_q && (state_q != StIdle)) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // Outputs
   always_comb begin
      busy       = (state_q != StIdle);
      frame_done = (state_q == StFin);
      // The VGA port is muted in the same cycle that done is seen.
      draw_pass  = (state_q == StDraw) && !sel_done;
      bus.x_position = draw_pass ? sel_x      : '0;
      bus.y_position = draw_pass ? sel_y      : '0;
      bus.colour     = draw_pass ? sel_colour : '0;
      bus.VGA_enable = draw_pass && sel_write;
      bus.ch_enable  = ch_enable_q;
      frame_tick     = tick_q;
      overrun        = overrun_q;
      frame_count    = frame_cnt_q;
   end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed self-checking bench for draw_sequencer (NUM_CH=3, FRAME_COUNT=64).
module tb_draw_sequencer;
   localparam int unsigned NCH = 3;
   localparam int unsigned XW  = 9;
   localparam int unsigned YW  = 8;
   localparam int unsigned CW  = 6;
   localparam int unsigned FC  = 64;
   localparam int unsigned XB  = NCH * XW;
   localparam int unsigned YB  = NCH * YW;
   localparam int unsigned CB  = NCH * CW;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         go = 1'b0;
   logic         overrun_clr = 1'b0;
   logic [2:0]   ch_mask = 3'b000;
   logic         frame_tick, frame_done, busy, overrun;
   logic [15:0]  frame_count;

   draw_sequencer_if #(.NUM_CH(NCH), .X_W(XW), .Y_W(YW), .C_W(CW)) bus ();

   draw_sequencer #(
      .NUM_CH(NCH), .X_W(XW), .Y_W(YW), .C_W(CW), .FRAME_COUNT(FC), .CNT_W(7)
   ) dut (
      .clock(clock),
      .reset(reset),
      .go(go),
      .ch_mask(ch_mask),
      .overrun_clr(overrun_clr),
      .bus(bus),
      .frame_tick(frame_tick),
      .frame_done(frame_done),
      .busy(busy),
      .overrun(overrun),
      .frame_count(frame_count)
   );

   always #5 clock = ~clock;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   bit         auto_done = 1'b0;
   int         age[3];
   logic [2:0] prev_en = 3'b000;
   logic [2:0] en_val[$];
   int         en_cyc[$];
   int         done_cyc[$];

   // Advance one clock and sample just after the edge. Each new non-zero
   // ch_enable value and each frame_done pulse is logged. When auto_done is
   // set, a channel raises done 4 cycles after its enable goes high.
   task automatic cycle();
      @(posedge clock);
      #1;
      cyc++;
      if (bus.ch_enable !== prev_en && bus.ch_enable !== 3'b000) begin
         en_val.push_back(bus.ch_enable);
         en_cyc.push_back(cyc);
      end
      prev_en = bus.ch_enable;
      if (frame_done === 1'b1) done_cyc.push_back(cyc);
      for (int k = 0; k < 3; k++) begin
         age[k] = (bus.ch_enable[k] === 1'b1) ? age[k] + 1 : 0;
         if (auto_done) bus.ch_done[k] = (age[k] > 4);
      end
   endtask

   task automatic step_to(input int c);
      while (cyc < c) cycle();
   endtask

   task automatic clear_logs();
      en_val.delete();
      en_cyc.delete();
      done_cyc.delete();
   endtask

   // Raise go and run up to the next tick. Go is dropped one cycle after the
   // tick, once the frame has been latched. t is the cycle of the tick.
   task automatic start_frame(output int t);
      int n;
      n = 0;
      t = -1000;
      go = 1'b1;
      while (n < 200 && t < 0) begin
         cycle();
         n++;
         if (frame_tick === 1'b1) t = cyc;
      end
      checks++;
      if (t < 0) begin
         failures++;
         $display("FAIL start_frame: got no frame_tick in 200 cycles, expected one");
      end
      cycle();
      go = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      #2 reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         go = 1'($urandom);
         ch_mask = 3'($urandom);
         overrun_clr = 1'($urandom);
         bus.ch_x = XB'($urandom);
         bus.ch_y = YB'($urandom);
         bus.ch_colour = CB'($urandom);
         bus.ch_write = 3'($urandom);
         bus.ch_done = 3'($urandom);
         cycle();
         checks++;
         if ({bus.ch_enable, bus.x_position, bus.y_position, bus.colour, bus.VGA_enable,
              frame_tick, frame_done, busy, overrun, frame_count} !== 47'd0) begin
            failures++;
            $display("FAIL reset_outputs: got en=%b x=%0h y=%0h c=%0h we=%b tick=%b done=%b busy=%b ovr=%b fc=%0d, expected all 0",
                     bus.ch_enable, bus.x_position, bus.y_position, bus.colour, bus.VGA_enable,
                     frame_tick, frame_done, busy, overrun, frame_count);
         end
      end
      go = 1'b0; ch_mask = '0; overrun_clr = 1'b0;
      bus.ch_x = '0; bus.ch_y = '0; bus.ch_colour = '0; bus.ch_write = '0; bus.ch_done = '0;
      reset = 1'b1;
      n = 0;
      while (n < 100 && frame_tick !== 1'b1) begin
         cycle();
         n++;
      end
      checks++;
      if (n != int'(FC)) begin
         failures++;
         $display("FAIL first_tick: got tick after %0d cycles, expected %0d", n, FC);
      end
      cycle();
      cycle();
      checks++;
      if (busy !== 1'b0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL tick_go_low: got busy=%b overrun=%b, expected 0 0", busy, overrun);
      end
   endtask

   task automatic test_ordered();
      int t;
      logic [2:0] exp_v[3];
      int exp_c[3];
      exp_v = '{3'b001, 3'b010, 3'b100};
      exp_c = '{2, 8, 14};
      clear_logs();
      auto_done = 1'b1;
      ch_mask = 3'b111;
      start_frame(t);
      ch_mask = 3'b000;  // a mask change mid-frame has no effect on this frame
      step_to(t + 30);
      checks++;
      if (en_val.size() != 3) begin
         failures++;
         $display("FAIL ordered_count: got %0d enables, expected 3", en_val.size());
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (en_val.size() <= i || en_val[i] !== exp_v[i] || en_cyc[i] != t + exp_c[i]) begin
            failures++;
            $display("FAIL ordered_enable%0d: got %0d entries, expected %b at tick+%0d",
                     i, en_val.size(), exp_v[i], exp_c[i]);
         end
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != t + 20) begin
         failures++;
         $display("FAIL ordered_done: got %0d pulses, expected 1 at tick+20", done_cyc.size());
      end
      checks++;
      if (frame_count !== 16'd1 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL ordered_count_ovr: got fc=%0d ovr=%b, expected 1 0", frame_count, overrun);
      end
   endtask

   task automatic test_mux();
      int t;
      int d;
      clear_logs();
      auto_done = 1'b0;
      bus.ch_done = '0;
      ch_mask = 3'b010;
      bus.ch_x = {9'd300, 9'd200, 9'd11};
      bus.ch_y = {8'd33, 8'd100, 8'd22};
      bus.ch_colour = {6'h15, 6'h2A, 6'h03};
      bus.ch_write = 3'b111;
      start_frame(t);
      step_to(t + 2);
      checks++;
      if (bus.ch_enable !== 3'b010 ||
          {bus.x_position, bus.y_position, bus.colour, bus.VGA_enable} !==
          {9'd200, 8'd100, 6'h2A, 1'b1}) begin
         failures++;
         $display("FAIL mux_pass: got en=%b x=%0d y=%0d c=%0h we=%b, expected 010 200 100 2a 1",
                  bus.ch_enable, bus.x_position, bus.y_position, bus.colour, bus.VGA_enable);
      end
      bus.ch_x = {9'd511, 9'd200, 9'd0};
      bus.ch_y = {8'd1, 8'd100, 8'd255};
      bus.ch_colour = {6'h3F, 6'h2A, 6'h00};
      bus.ch_write = 3'b010;
      bus.ch_done = 3'b101;
      cycle();
      checks++;
      if (bus.ch_enable !== 3'b010 ||
          {bus.x_position, bus.y_position, bus.colour, bus.VGA_enable} !==
          {9'd200, 8'd100, 6'h2A, 1'b1}) begin
         failures++;
         $display("FAIL mux_other_ch: got en=%b x=%0d y=%0d c=%0h we=%b, expected 010 200 100 2a 1",
                  bus.ch_enable, bus.x_position, bus.y_position, bus.colour, bus.VGA_enable);
      end
      bus.ch_write = 3'b000;
      #1;
      checks++;
      if (bus.VGA_enable !== 1'b0 || bus.x_position !== 9'd200) begin
         failures++;
         $display("FAIL mux_write: got we=%b x=%0d, expected 0 200", bus.VGA_enable, bus.x_position);
      end
      bus.ch_write = 3'b111;
      d = cyc;
      bus.ch_done = 3'b111;
      #1;
      checks++;
      if ({bus.x_position, bus.y_position, bus.colour, bus.VGA_enable} !== 24'd0 ||
          bus.ch_enable !== 3'b010) begin
         failures++;
         $display("FAIL mux_done_mute: got x=%0d y=%0d c=%0h we=%b en=%b, expected 0 0 0 0 010",
                  bus.x_position, bus.y_position, bus.colour, bus.VGA_enable, bus.ch_enable);
      end
      cycle();
      bus.ch_done = '0;
      checks++;
      if (bus.ch_enable !== 3'b000) begin
         failures++;
         $display("FAIL mux_en_drop: got %b, expected 000", bus.ch_enable);
      end
      step_to(d + 4);
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != d + 2 || frame_count !== 16'd2) begin
         failures++;
         $display("FAIL mux_frame_end: got %0d pulses fc=%0d, expected 1 pulse at done+2 fc=2",
                  done_cyc.size(), frame_count);
      end
   endtask

   task automatic test_mask();
      int t;
      clear_logs();
      auto_done = 1'b1;
      ch_mask = 3'b101;
      start_frame(t);
      step_to(t + 20);
      checks++;
      if (en_val.size() != 2 || en_val[0] !== 3'b001 || en_cyc[0] != t + 2 ||
          en_val[1] !== 3'b100 || en_cyc[1] != t + 8) begin
         failures++;
         $display("FAIL mask101_seq: got %0d enables, expected 001@tick+2 100@tick+8", en_val.size());
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != t + 14 || frame_count !== 16'd3) begin
         failures++;
         $display("FAIL mask101_done: got %0d pulses fc=%0d, expected 1 at tick+14 fc=3",
                  done_cyc.size(), frame_count);
      end
      clear_logs();
      ch_mask = 3'b000;
      start_frame(t);
      step_to(t + 5);
      checks++;
      if (en_val.size() != 0 || done_cyc.size() != 1 || done_cyc[0] != t + 2 ||
          frame_count !== 16'd4) begin
         failures++;
         $display("FAIL mask0: got %0d enables %0d pulses fc=%0d, expected 0 enables 1 pulse at tick+2 fc=4",
                  en_val.size(), done_cyc.size(), frame_count);
      end
   endtask

   task automatic test_overrun();
      int t;
      clear_logs();
      auto_done = 1'b0;
      bus.ch_done = '0;
      ch_mask = 3'b001;
      start_frame(t);
      step_to(t + 60);
      checks++;
      if (overrun !== 1'b0 || bus.ch_enable !== 3'b001) begin
         failures++;
         $display("FAIL ovr_pre: got ovr=%b en=%b, expected 0 001", overrun, bus.ch_enable);
      end
      overrun_clr = 1'b1;  // held across the tick so that set and clear coincide
      step_to(t + 64);
      checks++;
      if (frame_tick !== 1'b1) begin
         failures++;
         $display("FAIL ovr_tick: got tick=%b, expected 1 at tick+64", frame_tick);
      end
      cycle();
      overrun_clr = 1'b0;
      checks++;
      if (overrun !== 1'b1 || frame_count !== 16'd4 || bus.ch_enable !== 3'b001) begin
         failures++;
         $display("FAIL ovr_set: got ovr=%b fc=%0d en=%b, expected 1 4 001",
                  overrun, frame_count, bus.ch_enable);
      end
      bus.ch_done = 3'b001;
      cycle();
      bus.ch_done = '0;
      step_to(cyc + 4);
      checks++;
      if (overrun !== 1'b1 || frame_count !== 16'd5 || busy !== 1'b0 || en_val.size() != 1) begin
         failures++;
         $display("FAIL ovr_sticky: got ovr=%b fc=%0d busy=%b enables=%0d, expected 1 5 0 1",
                  overrun, frame_count, busy, en_val.size());
      end
      overrun_clr = 1'b1;
      cycle();
      overrun_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL ovr_clear: got %b, expected 0", overrun);
      end
   endtask

   task automatic test_go_reset();
      int t;
      clear_logs();
      auto_done = 1'b1;
      ch_mask = 3'b111;
      start_frame(t);
      step_to(t + 30);
      checks++;
      if (en_val.size() != 3 || done_cyc.size() != 1 || done_cyc[0] != t + 20 ||
          frame_count !== 16'd6) begin
         failures++;
         $display("FAIL go_low_frame: got %0d enables %0d pulses fc=%0d, expected 3 1@tick+20 6",
                  en_val.size(), done_cyc.size(), frame_count);
      end
      step_to(t + 70);
      checks++;
      if (busy !== 1'b0 || en_val.size() != 3 || frame_count !== 16'd6) begin
         failures++;
         $display("FAIL go_low_idle: got busy=%b enables=%0d fc=%0d, expected 0 3 6",
                  busy, en_val.size(), frame_count);
      end
      auto_done = 1'b0;
      bus.ch_done = '0;
      bus.ch_write = 3'b001;
      bus.ch_x = {9'd0, 9'd0, 9'd77};
      ch_mask = 3'b001;
      start_frame(t);
      step_to(t + 3);
      checks++;
      if (bus.VGA_enable !== 1'b1 || bus.x_position !== 9'd77) begin
         failures++;
         $display("FAIL rst_pre: got we=%b x=%0d, expected 1 77", bus.VGA_enable, bus.x_position);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (bus.VGA_enable !== 1'b0 || bus.x_position !== 9'd0 || bus.ch_enable !== 3'b000 ||
          busy !== 1'b0 || frame_count !== 16'd0) begin
         failures++;
         $display("FAIL rst_async: got we=%b x=%0d en=%b busy=%b fc=%0d, expected 0 0 000 0 0",
                  bus.VGA_enable, bus.x_position, bus.ch_enable, busy, frame_count);
      end
      cycle();
      reset = 1'b1;
      step_to(cyc + 5);
      checks++;
      if (busy !== 1'b0 || bus.ch_enable !== 3'b000) begin
         failures++;
         $display("FAIL rst_idle: got busy=%b en=%b, expected 0 000", busy, bus.ch_enable);
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) age[k] = 0;
      bus.ch_x = '0; bus.ch_y = '0; bus.ch_colour = '0; bus.ch_write = '0; bus.ch_done = '0;
      test_reset();
      test_ordered();
      test_mux();
      test_mask();
      test_overrun();
      test_go_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Parametrised frame pacer and VGA draw arbiter for the game datapath.
- Generates the frame tick. Once per frame it hands the VGA write port to NUM_CH sprite/layer drawers in fixed order: channel 0 (map/background) first, the highest channel last, so it draws on top.
- Muxes the active channel's x/y/colour/write onto the single VGA write port.
- Flags frame overruns.

Parameters:
NUM_CH, 3, number of draw channels (2..8)
X_W, 9, x coordinate width
Y_W, 8, y coordinate width
C_W, 6, colour width
FRAME_COUNT, 833333, clocks per frame (50MHz/60); minimum 4
CNT_W, 24, frame counter width; must satisfy 2^CNT_W > FRAME_COUNT

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
go  in  1  run enable; frames start only while high
ch_mask  in  NUM_CH  1 = channel drawn this frame; latched at frame start
ch_x  in  NUM_CH*X_W  per-channel x, channel k at bits [k*X_W +: X_W]
ch_y  in  NUM_CH*Y_W  per-channel y, same packing
ch_colour  in  NUM_CH*C_W  per-channel colour, same packing
ch_write  in  NUM_CH  per-channel VGA write request
ch_done  in  NUM_CH  per-channel draw-complete level
overrun_clr  in  1  clears overrun
ch_enable  out  NUM_CH  one-hot draw enable to the active channel
x_position  out  X_W  VGA x
y_position  out  Y_W  VGA y
colour  out  C_W  VGA colour
VGA_enable  out  1  VGA write enable
frame_tick  out  1  one-cycle pulse at each frame boundary (also the game-logic step)
frame_done  out  1  one-cycle pulse when all masked channels have finished
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky: a tick arrived while busy
frame_count  out  16  completed frames, wraps at 0xFFFF

Behaviour:
- Reset (reset=0, asynchronous): all of the following are 0.
  - counter, state=IDLE, cur index, latched mask
  - frame_tick, frame_done, overrun, frame_count, ch_enable
  - all VGA outputs
- Frame counter:
  - Free-running 0..FRAME_COUNT-1, then wraps to 0; runs regardless of go.
  - frame_tick is registered: high for the cycle after the counter equals FRAME_COUNT-1.
- FSM states: IDLE, SCAN, DRAW, FIN.
- IDLE:
  - If frame_tick=1 and go=1: latch ch_mask, set cur=0, go to SCAN.
  - If go=0: ticks are ignored, with no overrun.
- SCAN (1 cycle):
  - Find the lowest k >= cur with latched mask[k]=1.
  - If found: cur=k, go to DRAW.
  - Otherwise: go to FIN.
- DRAW:
  - ch_enable = one-hot(cur), registered.
  - While ch_done[cur]=0: VGA outputs are a combinational pass-through of channel cur (VGA_enable = ch_write[cur]).
  - When ch_done[cur]=1 is sampled: VGA outputs go to 0 that same cycle, ch_enable drops at the next edge, cur=cur+1, go to SCAN.
  - ch_done from non-active channels is ignored.
- FIN (1 cycle): frame_done=1, frame_count+=1, go to IDLE.
- Outside DRAW: x_position, y_position, colour and VGA_enable are 0.
- Latency:
  - Tick in cycle T → ch_enable[first] high in T+2.
  - Channel done → next channel enabled 2 cycles later.
  - Last channel done → frame_done pulse 2 cycles later.
- Mask 0 at frame start: SCAN→FIN directly. frame_done still pulses and frame_count still increments.
- Overrun:
  - A tick while state != IDLE sets overrun=1.
  - The tick is dropped, not queued; the current frame continues.
  - overrun_clr clears overrun. A set in the same cycle as a clear wins.
- go falling mid-frame: the current frame completes normally; no new frame starts.
- ch_mask changes mid-frame have no effect until the next frame start.
- Reset mid-draw: outputs go to 0 immediately (asynchronous); the sequencer restarts from IDLE.

Test Plan:
- Reset: hold reset=0 with random inputs → every output 0. Release → first frame_tick after FRAME_COUNT cycles.
- Ordered draw: FRAME_COUNT=64, NUM_CH=3, go=1, mask=3'b111, each channel raises ch_done 4 cycles after its enable → ch_enable sequence 001, 010, 100. frame_done pulses once; frame_count=1; overrun=0.
- Mux pass-through: during ch1 DRAW, drive ch1 x=9'd200, y=8'd100, colour=6'h2A, write=1 → identical values on the VGA outputs. Toggling ch0/ch2 inputs has no effect.
- Masking: mask=3'b101 → ch_enable[1] never asserts; ch2 is enabled 2 cycles after ch0 done. mask=0 → frame_done 2 cycles after the tick.
- Overrun: FRAME_COUNT=16, ch0 holds ch_done=0 for 40 cycles → overrun=1 at the next tick and frame_count stays 0. overrun_clr → overrun returns to 0.
- go and reset: drop go mid-frame → the frame completes and later ticks leave busy=0. Assert reset mid-DRAW → VGA_enable=0 in the same cycle and state returns to IDLE.
